// File: rtl/muldiv_sequencer.sv
//------------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// A start in IDLE latches the operands. PREP converts signed operands to
// magnitudes. ITER runs 32 shift-add (multiply) or restoring-divide steps.
// FIXUP restores the signs. DONE commits the 64-bit result to HI/LO.
// mthi/mtlo writes are accepted only in IDLE.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   start, op         begin mult(00)/multu(01)/div(10)/divu(11)
//   src_a, src_b      multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo      mthi/mtlo strobes carrying wr_data
//   busy              state is not IDLE (fetch stall)
//   done              one-cycle pulse in the commit cycle
//   div_zero          pulses with done for a zero divisor
//   hi_out, lo_out    registered architectural HI/LO
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module muldiv_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIXUP,
      S_DONE
   } state_t;

   state_t      state, state_nxt;

   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] opnd;      // multiplicand (mult) or divisor (div) magnitude
   logic [31:0] acc_hi;    // P_hi for multiply, remainder R for divide
   logic [31:0] acc_lo;    // P_lo for multiply, quotient Q for divide
   logic [4:0]  cnt;
   logic        neg_res;   // product / quotient must be negated
   logic        neg_rem;   // remainder must be negated (negative dividend)
   logic        dz_q;
   logic [31:0] hi_q, lo_q;

   logic        is_div, is_signed, b_zero;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [63:0] prod_neg;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];
   assign b_zero    = (b_q == 32'd0);
   assign a_mag     = (is_signed && a_q[31]) ? -a_q : a_q;
   assign b_mag     = (is_signed && b_q[31]) ? -b_q : b_q;

   // One multiply step: conditional add into P_hi with carry kept in bit 32.
   assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : 32'd0)};
   // One divide step: {R,Q} shifted left, then a 33-bit trial subtract.
   // R < divisor keeps the shifted value below 2*divisor, so 33 bits hold
   // both the sign and the magnitude of the difference.
   assign div_shift = {acc_hi, acc_lo[31]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign prod_neg  = -{acc_hi, acc_lo};

   // NOTE: every output of this always_comb gets a default before the case,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      div_zero  = (state == S_DONE) && dz_q;
      case (state)
         S_IDLE:  if (start) state_nxt = S_PREP;
         S_PREP:  state_nxt = (is_div && b_zero) ? S_DONE : S_ITER;
         S_ITER:  if (cnt == 5'd0) state_nxt = S_FIXUP;
         S_FIXUP: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments, so every
   // right-hand side here sees the pre-edge value regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         op_q    <= 2'b00;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         opnd    <= 32'd0;
         acc_hi  <= 32'd0;
         acc_lo  <= 32'd0;
         cnt     <= 5'd0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (wr_hi) hi_q <= wr_data;
               if (wr_lo) lo_q <= wr_data;
               if (start) begin
                  op_q <= op;
                  a_q  <= src_a;
                  b_q  <= src_b;
               end
            end
            S_PREP: begin
               cnt     <= 5'd31;
               neg_res <= is_signed & (a_q[31] ^ b_q[31]);
               neg_rem <= is_signed & is_div & a_q[31];
               dz_q    <= is_div & b_zero;
               acc_hi  <= 32'd0;
               if (is_div) begin
                  if (b_zero) begin
                     // Divide by zero skips ITER/FIXUP: HI = raw dividend,
                     // LO = all ones.
                     acc_hi <= a_q;
                     acc_lo <= 32'hFFFF_FFFF;
                  end else begin
                     acc_lo <= a_mag;
                     opnd   <= b_mag;
                  end
               end else begin
                  acc_lo <= b_mag;
                  opnd   <= a_mag;
               end
            end
            S_ITER: begin
               cnt <= cnt - 5'd1;
               if (is_div) begin
                  if (!div_diff[32]) begin
                     acc_hi <= div_diff[31:0];
                     acc_lo <= {acc_lo[30:0], 1'b1};
                  end else begin
                     acc_hi <= div_shift[31:0];
                     acc_lo <= {acc_lo[30:0], 1'b0};
                  end
               end else begin
                  acc_hi <= mul_sum[32:1];
                  acc_lo <= {mul_sum[0], acc_lo[31:1]};
               end
            end
            S_FIXUP: begin
               if (is_div) begin
                  // 0x80000000 / -1 wraps back to 0x80000000 here.
                  if (neg_res) acc_lo <= -acc_lo;
                  if (neg_rem) acc_hi <= -acc_hi;
               end else if (neg_res) begin
                  {acc_hi, acc_lo} <= prod_neg;
               end
            end
            S_DONE: begin
               hi_q <= acc_hi;
               lo_q <= acc_lo;
            end
            default: ;
         endcase
      end
   end

   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
//------------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed and random operations against a plain-arithmetic model of
// HI/LO. Each operation checks the done latency, the div_zero flag, busy
// staying high, the committed HI/LO, and that done lasts one cycle.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wr_data = 32'd0;
   logic        busy, done, div_zero;
   logic [31:0] hi_out, lo_out;

   int checks   = 0;
   int failures = 0;

   // Architectural HI/LO as the bench expects them to be.
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   muldiv_sequencer dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .wr_hi    (wr_hi),
      .wr_lo    (wr_lo),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result {HI, LO} from ordinary 64-bit arithmetic.
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub;
      logic [63:0]     q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'b00: return 64'(sa * sb);
         2'b01: return 64'(ua * ub);
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               q  = 64'(sq);
               r  = 64'(sr);
            end else begin
               q = ua / ub;
               r = ua % ub;
            end
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   task automatic write_reg(input logic sel_hi, input logic [31:0] data, input string tag);
      @(negedge clock);
      wr_hi   = sel_hi;
      wr_lo   = ~sel_hi;
      wr_data = data;
      @(posedge clock);
      #1;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      if (sel_hi) m_hi = data; else m_lo = data;
      check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, m_hi});
      check({tag, "_lo"}, {32'd0, lo_out}, {32'd0, m_lo});
   endtask

   // mode 0: plain op; 1: mtlo + second start in cycle 10 (ignored);
   // 2: async reset in cycle 20; 3: mthi in the same cycle as start.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int mode, input string tag);
      int   exp_lat;
      int   done_cyc;
      int   busy_low;
      logic dz_seen;
      exp_lat  = (o[1] && b == 32'd0) ? 2 : 35;
      done_cyc = 0;
      busy_low = 0;
      dz_seen  = 1'b0;
      @(negedge clock);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      if (mode == 3) begin
         wr_hi   = 1'b1;
         wr_data = 32'h5A5A_0003;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      wr_hi = 1'b0;
      if (mode == 3) m_hi = 32'h5A5A_0003;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (mode == 1 && n == 10) begin
            wr_lo   = 1'b1;
            wr_data = 32'hDEAD_BEEF;
            start   = 1'b1;
            op      = 2'b01;
            src_a   = 32'd7;
            src_b   = 32'd7;
         end
         if (mode == 1 && n == 11) begin
            wr_lo = 1'b0;
            start = 1'b0;
         end
         if ((mode == 1 && n == 20) || (mode == 3 && n == 5)) begin
            check({tag, "_mid_hi"}, {32'd0, hi_out}, {32'd0, m_hi});
            check({tag, "_mid_lo"}, {32'd0, lo_out}, {32'd0, m_lo});
         end
         if (mode == 2 && n == 20) begin
            #2;
            reset = 1'b0;
            #1;
            m_hi = 32'd0;
            m_lo = 32'd0;
            check({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
            check({tag, "_rst_hi"}, {32'd0, hi_out}, 64'd0);
            check({tag, "_rst_lo"}, {32'd0, lo_out}, 64'd0);
            @(negedge clock);
            reset = 1'b1;
            return;
         end
         if (!busy) busy_low++;
         if (done) begin
            done_cyc = n;
            dz_seen  = div_zero;
            break;
         end
      end
      check({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
      check({tag, "_div_zero"}, {63'd0, dz_seen}, {63'd0, (o[1] && b == 32'd0)});
      check({tag, "_busy_held"}, 64'(busy_low), 64'd0);
      @(posedge clock);
      #1;
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, m_hi});
      check({tag, "_lo"}, {32'd0, lo_out}, {32'd0, m_lo});
      check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;

      // Reset state.
      repeat (2) @(negedge clock);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {62'd0, done, div_zero}, 64'd0);
      check("reset_hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      // Directed cases with hand-derived results.
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "multu_max");
      do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, "mult_neg3x5");
      do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, "mult_minxmin");
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, "div_neg7by2");
      do_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, "divu_100by7");
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, "div_min_by_m1");
      do_op(2'b11, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 0, "divu_by_zero");

      // mthi in IDLE, then ignored mtlo/start while busy.
      write_reg(1'b1, 32'h0000_1234, "mthi");
      do_op(2'b00, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 1, "mult_ignore");

      // mthi alongside start: write lands now, result overwrites it later.
      do_op(2'b10, 32'hFFFF_FF9C, 32'd9, 64'hFFFF_FFFF_FFFF_FFF5, 3, "div_with_mthi");

      // Async reset mid-divide, then a clean multu.
      do_op(2'b10, 32'd1000, 32'd3, 64'd0, 2, "div_reset");
      do_op(2'b01, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 0, "multu_after_rst");

      // Random operations checked against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         case ($urandom_range(0, 7))
            0:       r_b = 32'd0;
            1:       r_b = 32'($urandom_range(1, 15));
            2:       r_b = 32'hFFFF_FFFF;
            default: r_b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) write_reg($urandom_range(0, 1) == 1, $urandom, "rand_wr");
         do_op(r_op, r_a, r_b, ref_op(r_op, r_a, r_b), 0, "rand_op");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
